// File: rtl/irq_controller.sv
// Interrupt sequencer: latches event pulses as pending bits, picks one by fixed priority,
// and walks the cpu through request, take and IACK under a global IEN/IDIS enable.
module irq_controller #(
  parameter int N_SRC = 3,
  parameter int CW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_pulse,
  input  logic             ien,
  input  logic             idis,
  input  logic             iack,
  input  logic             irq_take,
  output logic             irq,
  output logic [CW-1:0]    irq_cause,
  output logic             irq_busy,
  output logic [N_SRC-1:0] pending,
  output logic             int_en,
  output logic [7:0]       drop_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               irq_r;
  logic               irq_nxt_s;
  logic [CW-1:0]      cause_r;
  logic [CW-1:0]      cause_nxt_s;
  logic               busy_r;
  logic               busy_nxt_s;
  logic [N_SRC-1:0]   pending_r;
  logic [N_SRC-1:0]   clr_s;
  logic               drop_any_s;
  logic               int_en_r;
  logic [7:0]         drop_cnt_r;

  // Lowest set index wins: index 0 is the highest priority source.
  function automatic logic [CW-1:0] first_pending(input logic [N_SRC-1:0] p);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (p[i]) begin
        idx = CW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Pending-clear mask from an IACK in service, and detection of pulses lost on set bits.
  always_comb begin
    clr_s = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if ((state_r == SERVICE) && iack && (CW'(i) == cause_r)) begin
        clr_s[i] = 1'b1;
      end else begin
        clr_s[i] = 1'b0;
      end
    end
    // A pulse on the bit being acknowledged re-arms it rather than counting as a drop.
    drop_any_s = |(src_pulse & pending_r & ~clr_s);
  end

  // Next-state and registered-output values of the request/service sequencer.
  always_comb begin
    state_nxt_s = state_r;
    irq_nxt_s   = irq_r;
    cause_nxt_s = cause_r;
    busy_nxt_s  = busy_r;
    case (state_r)
      IDLE: begin
        busy_nxt_s = 1'b0;
        if (int_en_r && (|pending_r)) begin
          state_nxt_s = REQ;
          irq_nxt_s   = 1'b1;
          cause_nxt_s = first_pending(pending_r);
        end else begin
          irq_nxt_s = 1'b0;
        end
      end
      REQ: begin
        if (irq_take) begin
          state_nxt_s = SERVICE;
          irq_nxt_s   = 1'b0;
          busy_nxt_s  = 1'b1;
        end else if (idis) begin
          state_nxt_s = IDLE;
          irq_nxt_s   = 1'b0;
        end else begin
          irq_nxt_s = 1'b1;
        end
      end
      SERVICE: begin
        irq_nxt_s = 1'b0;
        if (iack) begin
          state_nxt_s = IDLE;
          busy_nxt_s  = 1'b0;
        end else begin
          busy_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        irq_nxt_s   = 1'b0;
        cause_nxt_s = '0;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, outputs, pending bits, global enable and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      irq_r      <= 1'b0;
      cause_r    <= '0;
      busy_r     <= 1'b0;
      pending_r  <= '0;
      int_en_r   <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else begin
      state_r   <= state_nxt_s;
      irq_r     <= irq_nxt_s;
      cause_r   <= cause_nxt_s;
      busy_r    <= busy_nxt_s;
      pending_r <= (pending_r & ~clr_s) | src_pulse;
      if (idis) begin
        int_en_r <= 1'b0;
      end else if (ien) begin
        int_en_r <= 1'b1;
      end else begin
        int_en_r <= int_en_r;
      end
      if (drop_any_s && (drop_cnt_r != 8'd255)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  assign irq       = irq_r;
  assign irq_cause = cause_r;
  assign irq_busy  = busy_r;
  assign pending   = pending_r;
  assign int_en    = int_en_r;
  assign drop_cnt  = drop_cnt_r;

endmodule
